nes_controller: RTL
===================

# nes_controller

Cycle-accurate model of the standard NES joypad: the responder on the `$4016`/`$4017` serial controller port that `cpu_memory` drives. It takes eight raw button inputs, synchronizes and debounces them, and optionally applies turbo to A/B. It captures the button state while strobed and shifts it out one bit per CPU read on the active-low serial line feeding `ctlr_data_p1` or `ctlr_data_p2`. Two instances sit beside `cpu_memory` in the full system.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable `clock` cycles required before a debounced button changes. Legal range 1..65535.
- `TURBO_FRAMES`, default 2: number of latch falling edges per turbo half-period. Legal range 1..255.

Ports:
- `clock` in, 1: system master clock.
- `reset` in, 1: synchronous, active-high.
- `clock_en` in, 1: CPU clock enable (master/12). Qualifies `ctlr_latch` and `ctlr_pulse`.
- `ctlr_latch` in, 1: strobe level, the last value written to `$4016` bit 0.
- `ctlr_pulse` in, 1: asserted for the one `clock_en` cycle in which the CPU reads this port.
- `buttons` in, 8: raw asynchronous buttons, active-high. Bit order: [0] A, [1] B, [2] Select, [3] Start, [4] Up, [5] Down, [6] Left, [7] Right.
- `turbo_a`, `turbo_b` in, 1 each: turbo enables, asynchronous, synchronized internally.
- `ctlr_data` out, 1: serial data, active-low (0 = pressed).
- `read_count` out, 4: reads since the last latch. Saturates at 9.

## Operation
- Synchronizer: two flops per input on `buttons`, `turbo_a`, `turbo_b`.
- Debounce, per button:
  - A counter clears whenever the synchronized value equals the debounced value.
  - Otherwise the counter increments each `clock`.
  - When the counter reaches `DEBOUNCE_CYCLES - 1` and the input still differs, the debounced value takes the new level and the counter clears.
  - Runs on every `clock`, not gated by `clock_en`.
- Turbo:
  - An 8-bit frame counter advances on each `clock_en` cycle where `ctlr_latch` goes 1 to 0.
  - At `TURBO_FRAMES - 1` the counter wraps to 0 and toggles `turbo_phase`.
  - Effective A = debounced A & (~`turbo_a` | `turbo_phase`). Same rule for B with `turbo_b`.
- Shift register `sr[7:0]` holds active-low data; `ctlr_data = sr[0]`.
- Per `clock_en` cycle, in priority order:
  - `ctlr_latch` = 1: `sr <= ~effective_buttons`, `read_count <= 0`. Reload happens every enabled cycle while high, so `ctlr_data` tracks A live. `ctlr_pulse` is ignored.
  - `ctlr_latch` = 0 and `ctlr_pulse` = 1: `sr <= {1'b0, sr[7:1]}`, `read_count <= min(read_count + 1, 9)`.
  - Otherwise: hold.
- After 8 reads `sr` is all zeros, so the line reads low. The console inverts the line, so the CPU sees 1, matching an official pad.
- `turbo_phase` changes only on latch falling edges, so turbo never alters data mid-read.

## Timing
- Reset values: `sr` = 8'hFF, `ctlr_data` = 1, `read_count` = 0, debounced buttons = 0, debounce counters = 0, synchronizers = 0, frame counter = 0, `turbo_phase` = 0.
- Reset forces these values regardless of `clock_en`, including during a read sequence.
- `ctlr_data` is a flop output. `cpu_memory` samples it in the same `clock_en` cycle that `ctlr_pulse` is high; the shift lands on that edge, and the next bit is visible from the following `clock`.
- Button-to-debounced latency: 2 sync cycles + `DEBOUNCE_CYCLES` clocks.
- Latch-to-data: the first enabled cycle with `ctlr_latch` = 1 loads `sr`, and `ctlr_data` is valid one `clock` later.
- Inputs with `clock_en` = 0 have no effect on `sr` or `read_count`.
- Latch and pulse in the same enabled cycle: load wins, no shift, `read_count` = 0.

## Structure
- `ctlr_pkg` holds:
  - `btn_idx_t` enum (BTN_A=0 … BTN_RIGHT=7).
  - `CTLR_READ_SAT` = 4'd9.
  - `CTLR_FILL` = 1'b0.
- Sub-module `button_debounce`: parameterized `DEBOUNCE_CYCLES`, ports `clock`, `reset`, `in_sync`, `out`. Instantiated 8×.
- Synchronizers, turbo logic and the shift register live in the top.

## Test plan
- Reset, then hold `buttons` = 8'h00, pulse latch, do 8 reads: `ctlr_data` = 1,1,1,1,1,1,1,1, then 0 on reads 9–12, with `read_count` ending at 9.
- Hold `buttons` = 8'b1000_1001 (A, Start, Right) stable for more than 18 clocks, latch, then read: serial sequence 0,1,1,0,1,1,1,0.
- Glitch on A for 10 clocks with `DEBOUNCE_CYCLES` = 16: no change after the latch. A held for 18 clocks: change seen.
- Keep `ctlr_latch` high, toggle A, and issue pulses: `ctlr_data` follows ~A, no shift occurs, `read_count` stays 0.
- `turbo_a` = 1 with A held and `TURBO_FRAMES` = 2: the first read after successive latch falls is 1,1,0,0,1,1… (reset phase 0 = released).
- Assert reset after 3 reads: next cycle `ctlr_data` = 1, `read_count` = 0; the next latch reloads correctly.

Source files
------------

// File: rtl/ctlr_pkg.sv
// Shared definitions for the NES joypad responder.
//   btn_idx_t     : bit position of each button inside the 8-bit button vector
//   CTLR_READ_SAT : read_count saturation value (reads past the 8 data bits)
//   CTLR_FILL     : bit shifted into the top of the shift register on each read
package ctlr_pkg;

  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_idx_t;

  localparam logic [3:0] CTLR_READ_SAT = 4'd9;
  localparam logic       CTLR_FILL     = 1'b0;

endpackage

// File: rtl/nes_controller_if.sv
// Serial controller port between cpu_memory (master) and the joypad (slave).
//   clock_en   : CPU clock enable, qualifies ctlr_latch / ctlr_pulse
//   ctlr_latch : strobe level ($4016 bit 0)
//   ctlr_pulse : one clock_en cycle wide read strobe
//   ctlr_data  : active-low serial data from the pad
//   read_count : reads since the last latch, saturating at 9
interface nes_controller_if;

  logic       clock_en;
  logic       ctlr_latch;
  logic       ctlr_pulse;
  logic       ctlr_data;
  logic [3:0] read_count;

  modport master (
    output clock_en, ctlr_latch, ctlr_pulse,
    input  ctlr_data, read_count
  );

  modport slave (
    input  clock_en, ctlr_latch, ctlr_pulse,
    output ctlr_data, read_count
  );

endinterface

// File: rtl/button_debounce.sv
// Single-button debouncer. The output follows in_sync only after the input has
// differed from the current output for DEBOUNCE_CYCLES consecutive clocks.
//   clock   : system clock
//   reset   : synchronous active-high reset (output and counter cleared)
//   in_sync : already-synchronized button level
//   out     : debounced button level
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic in_sync,
  output logic out
);

  localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt_q;
  logic        out_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else if (in_sync == out_q) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST_COUNT) begin
      out_q <= in_sync;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/nes_controller.sv
// NES joypad responder for the $4016/$4017 serial port.
// Synchronizes and debounces eight buttons, optionally applies turbo to A/B,
// captures the state while strobed and shifts it out one bit per CPU read.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : serial port (clock_en, ctlr_latch, ctlr_pulse in;
//                  ctlr_data, read_count out)
//   buttons      : raw asynchronous buttons, active-high, A in bit 0
//   turbo_a/b    : asynchronous turbo enables for A and B
module nes_controller
  import ctlr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TURBO_FRAMES    = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  nes_controller_if.slave        bus,
  input  logic [7:0]             buttons,
  input  logic                   turbo_a,
  input  logic                   turbo_b
);

  localparam logic [7:0] LAST_FRAME = 8'(TURBO_FRAMES - 1);

  // Two-flop synchronizer: {turbo_b, turbo_a, buttons}
  logic [9:0] sync1_q, sync2_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {turbo_b, turbo_a, buttons};
      sync2_q <= sync1_q;
    end
  end

  logic [7:0] debounced;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_debounce
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clock   (clock),
        .reset   (reset),
        .in_sync (sync2_q[gi]),
        .out     (debounced[gi])
      );
    end
  endgenerate

  // Turbo phase advances only on latch falling edges, never mid-read.
  logic       latch_prev_q;
  logic [7:0] frame_cnt_q;
  logic       turbo_phase_q;
  logic       latch_fall;

  assign latch_fall = bus.clock_en & latch_prev_q & ~bus.ctlr_latch;

  always_ff @(posedge clock) begin
    if (reset) begin
      latch_prev_q  <= 1'b0;
      frame_cnt_q   <= '0;
      turbo_phase_q <= 1'b0;
    end else begin
      if (bus.clock_en) latch_prev_q <= bus.ctlr_latch;
      if (latch_fall) begin
        if (frame_cnt_q == LAST_FRAME) begin
          frame_cnt_q   <= '0;
          turbo_phase_q <= ~turbo_phase_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 8'd1;
        end
      end
    end
  end

  // With turbo enabled, A/B are only reported during the "pressed" phase.
  logic [7:0] effective;
  always_comb begin
    effective         = debounced;
    effective[BTN_A]  = debounced[BTN_A] & (~sync2_q[8] | turbo_phase_q);
    effective[BTN_B]  = debounced[BTN_B] & (~sync2_q[9] | turbo_phase_q);
  end

  // Shift register holds active-low data; latch has priority over pulse.
  logic [7:0] sr_q, sr_d;
  logic [3:0] read_count_q, read_count_d;

  always_comb begin
    sr_d         = sr_q;
    read_count_d = read_count_q;
    if (bus.clock_en) begin
      if (bus.ctlr_latch) begin
        sr_d         = ~effective;
        read_count_d = '0;
      end else if (bus.ctlr_pulse) begin
        sr_d = {CTLR_FILL, sr_q[7:1]};
        if (read_count_q != CTLR_READ_SAT) read_count_d = read_count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q         <= 8'hFF;
      read_count_q <= '0;
    end else begin
      sr_q         <= sr_d;
      read_count_q <= read_count_d;
    end
  end

  assign bus.ctlr_data  = sr_q[0];
  assign bus.read_count = read_count_q;

endmodule
